// File: rtl/xalu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// xalu_issue_ctrl_if
//
// Bundle between the E-stage decode / pipeline control and the XALU issue
// controller. The controller takes the slave view; whoever drives the
// instruction stream and the XALU Busy line takes the master view.
//
// Signals (direction seen from the controller):
//   InstrValid  in   E stage holds a HI/LO-class instruction
//   InstrOp     in   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo,
//                    6 mfhi, 7 mflo
//   Flush       in   E-stage instruction is killed this cycle
//   Busy        in   XALU busy (registered inside the XALU)
//   Start       out  0 none, 1 mult/div launch, 2 mthi/mtlo write
//   XALUOp      out  InstrOp when Start != 0, else 0
//   Stall       out  freeze F/D/E and bubble M
//   HiLoSel     out  mf read-mux select: 1 HI, 0 LO
//   MfValid     out  mf result may be captured this cycle
//   Error       out  sticky Busy / tracking disagreement
//   IssueCount  out  saturating count of launches
//   StallCount  out  saturating count of stall cycles
// ---------------------------------------------------------------------------
interface xalu_issue_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             InstrValid;
  logic [2:0]       InstrOp;
  logic             Flush;
  logic             Busy;
  logic [1:0]       Start;
  logic [2:0]       XALUOp;
  logic             Stall;
  logic             HiLoSel;
  logic             MfValid;
  logic             Error;
  logic [CNT_W-1:0] IssueCount;
  logic [CNT_W-1:0] StallCount;

  modport slave (
    input  InstrValid, InstrOp, Flush, Busy,
    output Start, XALUOp, Stall, HiLoSel, MfValid, Error,
           IssueCount, StallCount
  );

  modport master (
    output InstrValid, InstrOp, Flush, Busy,
    input  Start, XALUOp, Stall, HiLoSel, MfValid, Error,
           IssueCount, StallCount
  );
endinterface

// File: rtl/xalu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// xalu_issue_ctrl
//
// Issue and hazard controller for the multiply/divide unit (XALU) in the
// E stage. Turns the E-stage HI/LO-class instruction into the XALU
// Start/XALUOp command, stalls the pipeline while a multiply or divide is
// in flight, tracks the expected completion with a private latency counter
// and cross-checks that against the XALU Busy line. Two saturating
// performance counters record launches and stall cycles.
//
// Parameters:
//   MULT_LAT  cycles Busy stays high after a mult/multu issue edge (<= 15)
//   DIV_LAT   cycles Busy stays high after a div/divu issue edge  (<= 15)
//   CNT_W     performance counter width; must match the interface
//
// Ports:
//   i_clk    in   system clock, rising edge
//   i_rst_n  in   asynchronous active-low reset
//   bus      slave view of xalu_issue_ctrl_if (see that file)
// ---------------------------------------------------------------------------
module xalu_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  xalu_issue_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_RUN,
    S_DIV_RUN,
    S_OVERRUN
  } state_t;

  localparam logic [3:0] MULT_REM = 4'(MULT_LAT);
  localparam logic [3:0] DIV_REM  = 4'(DIV_LAT);

  // Start encodings driven to the XALU.
  localparam logic [1:0] START_NONE   = 2'd0;
  localparam logic [1:0] START_LAUNCH = 2'd1;
  localparam logic [1:0] START_WRITE  = 2'd2;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_rem;
  logic [3:0]       w_rem_nxt;
  logic             r_error;
  logic             w_error_nxt;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_req;
  logic             w_op_launch;
  logic             w_op_mt;
  logic [1:0]       w_start;
  logic [2:0]       w_xalu_op;
  logic             w_stall;
  logic             w_mf_valid;

  // A flushed instruction is invisible to the controller: no launch, no
  // mf capture and no stall on its behalf.
  assign w_req       = bus.InstrValid & ~bus.Flush;
  assign w_op_launch = ~bus.InstrOp[2];
  assign w_op_mt     = (bus.InstrOp[2:1] == 2'b10);

  // ---------------------------------------------------------------------
  // Next-state and command decode
  // ---------------------------------------------------------------------
  // NOTE: every signal written here gets a default before the case, so no
  // path through the block can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_error_nxt = r_error;
    w_start     = START_NONE;
    w_stall     = 1'b0;
    w_mf_valid  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_op_launch) begin
            w_start = START_LAUNCH;
          end else if (w_op_mt) begin
            w_start = START_WRITE;
          end else begin
            w_mf_valid = 1'b1;
          end
        end

        // Busy while we believe the XALU is idle means tracking is already
        // lost; wait in OVERRUN until the XALU drains rather than trusting
        // a fresh latency count.
        if (bus.Busy) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_OVERRUN;
        end else if (w_start == START_LAUNCH) begin
          // Ops 2/3 (div/divu) have InstrOp[1] set; 0/1 are multiplies.
          if (bus.InstrOp[1]) begin
            w_state_nxt = S_DIV_RUN;
            w_rem_nxt   = DIV_REM;
          end else begin
            w_state_nxt = S_MUL_RUN;
            w_rem_nxt   = MULT_REM;
          end
        end
      end

      S_MUL_RUN, S_DIV_RUN: begin
        // Anything HI/LO-class waits, including a new launch or mt that
        // would clobber the in-flight result.
        w_stall   = w_req;
        w_rem_nxt = r_rem - 4'd1;
        if (r_rem <= 4'd1) begin
          w_state_nxt = S_IDLE;
          w_rem_nxt   = 4'd0;
        end else if (!bus.Busy) begin
          // XALU finished earlier than its fixed latency.
          w_error_nxt = 1'b1;
          w_state_nxt = S_IDLE;
          w_rem_nxt   = 4'd0;
        end
      end

      S_OVERRUN: begin
        w_stall = w_req;
        if (!bus.Busy) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_rem_nxt   = 4'd0;
      end
    endcase
  end

  assign w_xalu_op = (w_start != START_NONE) ? bus.InstrOp : 3'd0;

  // ---------------------------------------------------------------------
  // State, sticky error and performance counters
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rem       <= 4'd0;
      r_error     <= 1'b0;
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_error <= w_error_nxt;

      // Both counters stick at all-ones instead of wrapping.
      if ((w_start == START_LAUNCH) && (r_issue_cnt != '1)) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.Start      = w_start;
  assign bus.XALUOp     = w_xalu_op;
  assign bus.Stall      = w_stall;
  assign bus.MfValid    = w_mf_valid;
  // Pure decode; consumers qualify it with MfValid.
  assign bus.HiLoSel    = (bus.InstrOp == 3'd6);
  assign bus.Error      = r_error;
  assign bus.IssueCount = r_issue_cnt;
  assign bus.StallCount = r_stall_cnt;

endmodule

// File: tb/tb_xalu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_xalu_issue_ctrl
//
// Drives two controllers (CNT_W = 16 and CNT_W = 4) with the same
// instruction stream. A small XALU stand-in generates Busy from the
// expected launches, with an override for fault scenarios. Expected values
// come from a cycle-stamp reference model: an operation issued in cycle c
// keeps the pipeline busy until cycle c + LAT + 1.
// ---------------------------------------------------------------------------
module tb_xalu_issue_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  xalu_issue_ctrl_if #(.CNT_W(16)) b16 ();
  xalu_issue_ctrl_if #(.CNT_W(4))  b4 ();

  xalu_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(16)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (b16.slave)
  );

  xalu_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) u_dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (b4.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_cyc;
  int m_done_at;   // first cycle no longer occupied by the current op
  bit m_ovr;       // waiting for an unexpected Busy to drop
  bit m_err;
  int m_issue;
  int m_stall;

  // Model predictions for the current cycle.
  bit [1:0] e_start;
  bit [2:0] e_xop;
  bit       e_stall;
  bit       e_hls;
  bit       e_mfv;

  // XALU stand-in.
  int x_cnt;
  bit force_en;
  bit force_val;
  bit cur_busy;

  // Last observed outputs of the 16-bit instance.
  logic [1:0]  o_start;
  logic [2:0]  o_xop;
  logic        o_stall;
  logic        o_mfv;
  logic        o_hls;
  logic        o_err;
  logic [15:0] o_issue;
  logic [15:0] o_stalls;
  logic [3:0]  o_issue4;
  logic [3:0]  o_stall4;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit [2:0] op, input bit f);
    b16.InstrValid = v;  b4.InstrValid = v;
    b16.InstrOp    = op; b4.InstrOp    = op;
    b16.Flush      = f;  b4.Flush      = f;
    cur_busy = force_en ? force_val : (x_cnt > 0);
    b16.Busy = cur_busy; b4.Busy = cur_busy;
  endtask

  task automatic sample();
    o_start  = b16.Start;
    o_xop    = b16.XALUOp;
    o_stall  = b16.Stall;
    o_mfv    = b16.MfValid;
    o_hls    = b16.HiLoSel;
    o_err    = b16.Error;
    o_issue  = b16.IssueCount;
    o_stalls = b16.StallCount;
    o_issue4 = b4.IssueCount;
    o_stall4 = b4.StallCount;
  endtask

  task automatic model_reset();
    m_cyc     = 0;
    m_done_at = 0;
    m_ovr     = 1'b0;
    m_err     = 1'b0;
    m_issue   = 0;
    m_stall   = 0;
    x_cnt     = 0;
    force_en  = 1'b0;
    force_val = 1'b0;
  endtask

  task automatic model_eval(input bit v, input bit [2:0] op, input bit f);
    bit req;
    req     = v && !f;
    e_start = 2'd0;
    e_stall = 1'b0;
    e_mfv   = 1'b0;
    if ((m_cyc < m_done_at) || m_ovr) begin
      e_stall = req;
    end else if (req) begin
      if (op < 3'd4)      e_start = 2'd1;
      else if (op < 3'd6) e_start = 2'd2;
      else                e_mfv   = 1'b1;
    end
    e_xop = (e_start != 2'd0) ? op : 3'd0;
    e_hls = (op == 3'd6);
  endtask

  task automatic model_edge(input bit [2:0] op);
    int lat;
    lat = (op >= 3'd2) ? DIV_LAT : MULT_LAT;
    if (e_stall) m_stall++;
    if (e_start == 2'd1) m_issue++;
    if (m_cyc < m_done_at) begin
      if (!cur_busy && (m_done_at - m_cyc) > 1) begin
        m_err     = 1'b1;
        m_done_at = m_cyc + 1;
      end
    end else if (m_ovr) begin
      if (!cur_busy) m_ovr = 1'b0;
    end else if (cur_busy) begin
      m_err = 1'b1;
      m_ovr = 1'b1;
    end else if (e_start == 2'd1) begin
      m_done_at = m_cyc + 1 + lat;
    end
    if (e_start == 2'd1)  x_cnt = lat;
    else if (x_cnt > 0)   x_cnt--;
    m_cyc++;
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, advance
  // the model at the rising edge, return at the next falling edge.
  task automatic step(input bit v, input bit [2:0] op, input bit f);
    drive(v, op, f);
    model_eval(v, op, f);
    #1;
    sample();
    chk("start",    32'(o_start),  32'(e_start));
    chk("xaluop",   32'(o_xop),    32'(e_xop));
    chk("stall",    32'(o_stall),  32'(e_stall));
    chk("mfvalid",  32'(o_mfv),    32'(e_mfv));
    chk("hilosel",  32'(o_hls),    32'(e_hls));
    chk("error",    32'(o_err),    32'(m_err));
    chk("issue16",  32'(o_issue),  sat(m_issue, 65535));
    chk("stall16",  32'(o_stalls), sat(m_stall, 65535));
    chk("issue4",   32'(o_issue4), sat(m_issue, 15));
    chk("stall4",   32'(o_stall4), sat(m_stall, 15));
    chk("start4",   32'(b4.Start), 32'(e_start));
    chk("error4",   32'(b4.Error), 32'(m_err));
    @(posedge clk);
    model_edge(op);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1'b0, 3'd0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    sample();
    chk("rst_start",   32'(o_start),  32'd0);
    chk("rst_xaluop",  32'(o_xop),    32'd0);
    chk("rst_stall",   32'(o_stall),  32'd0);
    chk("rst_mfvalid", 32'(o_mfv),    32'd0);
    chk("rst_hilosel", 32'(o_hls),    32'd0);
    chk("rst_error",   32'(o_err),    32'd0);
    chk("rst_issue",   32'(o_issue),  32'd0);
    chk("rst_stalls",  32'(o_stalls), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int n;
    model_reset();

    // Reset, then idle with Busy low keeps Error clear.
    do_reset();
    repeat (3) step(1'b0, 3'd0, 1'b0);
    chk("idle_error", 32'(o_err), 32'd0);

    // mult in cycle 0, dependent mfhi from cycle 1.
    step(1'b1, 3'd0, 1'b0);
    chk("mult_start",  32'(o_start), 32'd1);
    chk("mult_xaluop", 32'(o_xop),   32'd0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 3'd6, 1'b0);
      chk("mult_mf_stall", 32'(o_stall), 32'd1);
    end
    step(1'b1, 3'd6, 1'b0);
    chk("mult_mf_valid",  32'(o_mfv),   32'd1);
    chk("mult_mf_hisel",  32'(o_hls),   32'd1);
    chk("mult_mf_nostall", 32'(o_stall), 32'd0);
    step(1'b0, 3'd0, 1'b0);
    chk("mult_issue_cnt", 32'(o_issue),  32'd1);
    chk("mult_stall_cnt", 32'(o_stalls), 32'd5);

    // divu then mflo: exactly ten stall cycles, result in cycle 11.
    do_reset();
    step(1'b1, 3'd3, 1'b0);
    chk("divu_start",  32'(o_start), 32'd1);
    chk("divu_xaluop", 32'(o_xop),   32'd3);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 3'd7, 1'b0);
      n += int'(o_stall);
    end
    chk("divu_stall_cycles", n, 32'd10);
    step(1'b1, 3'd7, 1'b0);
    chk("divu_mf_valid", 32'(o_mfv),   32'd1);
    chk("divu_mf_losel", 32'(o_hls),   32'd0);
    chk("divu_nostall",  32'(o_stall), 32'd0);

    // mthi flushed while a mult runs: no stall, no start, run still ends.
    do_reset();
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd4, 1'b0);
    chk("mt_inflight_stall", 32'(o_stall), 32'd1);
    step(1'b1, 3'd4, 1'b1);
    chk("flush_stall", 32'(o_stall), 32'd0);
    chk("flush_start", 32'(o_start), 32'd0);
    repeat (3) step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd6, 1'b0);
    chk("flush_idle_at_6", 32'(o_mfv), 32'd1);
    // mthi then mfhi back to back: no stall either way.
    step(1'b1, 3'd4, 1'b0);
    chk("mthi_start", 32'(o_start), 32'd2);
    step(1'b1, 3'd6, 1'b0);
    chk("mthi_mfhi_valid", 32'(o_mfv), 32'd1);

    // Busy held high for 8 cycles after a multu: overrun.
    do_reset();
    step(1'b1, 3'd1, 1'b0);
    force_en  = 1'b1;
    force_val = 1'b1;
    repeat (6) step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd6, 1'b0);
    chk("ovr_error", 32'(o_err),   32'd1);
    chk("ovr_stall", 32'(o_stall), 32'd1);
    chk("ovr_nomf",  32'(o_mfv),   32'd0);
    step(1'b1, 3'd6, 1'b0);
    force_val = 1'b0;
    step(1'b1, 3'd6, 1'b0);
    chk("ovr_drop_stall", 32'(o_stall), 32'd1);
    step(1'b1, 3'd6, 1'b0);
    chk("ovr_back_idle", 32'(o_mfv), 32'd1);
    chk("ovr_sticky",    32'(o_err), 32'd1);

    // Busy dropped early in a div.
    do_reset();
    step(1'b1, 3'd2, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    force_en  = 1'b1;
    force_val = 1'b0;
    step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd6, 1'b0);
    chk("early_error", 32'(o_err), 32'd1);
    chk("early_idle",  32'(o_mfv), 32'd1);

    // Asynchronous reset in the middle of a mult.
    do_reset();
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd6, 1'b0);
    step(1'b1, 3'd6, 1'b0);
    drive(1'b1, 3'd6, 1'b0);
    #1;
    chk("pre_arst_stall", 32'(b16.Stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_stall",  32'(b16.Stall),      32'd0);
    chk("arst_idle",   32'(b16.MfValid),    32'd1);
    chk("arst_issue",  32'(b16.IssueCount), 32'd0);
    chk("arst_stalls", 32'(b16.StallCount), 32'd0);
    @(negedge clk);

    // Counter saturation: 19 back-to-back mults.
    do_reset();
    for (int k = 0; k < 19 * 6; k++) step(1'b1, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    chk("sat_issue4",  32'(o_issue4), 32'd15);
    chk("sat_stall4",  32'(o_stall4), 32'd15);
    chk("sat_issue16", 32'(o_issue),  32'd19);
    chk("sat_stall16", 32'(o_stalls), 32'd95);

    // Random traffic against a well-behaved XALU.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
